// File: rtl/regfile_mp_if.sv
// Bundle of the register-file access signals shared by the core (master) and regfile_mp (slave).
// Read and write ports are packed; port i occupies slice [i*AW +: AW] or [i*XLEN +: XLEN].
interface regfile_mp_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NR   = 2,
    parameter int NW   = 1
);
    localparam int AW = $clog2(NREG);

    logic               init_done;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*XLEN-1:0] wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [AW-1:0]      dbg_addr;
    logic [XLEN-1:0]    dbg_data;

    modport master (
        input  init_done, rd_data, rd_busy, dbg_data,
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr
    );

    modport slave (
        output init_done, rd_data, rd_busy, dbg_data,
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hard-wired x0, optional write-to-read bypass,
// per-register busy scoreboard and a post-reset sweep that zeroes every register.
module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NR     = 2,
    parameter int NW     = 1,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst_n,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   init_cnt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_next, busy_set, busy_clr;
    logic            ready;

    assign ready         = (state == S_READY);
    assign bus.init_done = ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == S_INIT && init_cnt == AW'(NREG - 1))
            state_next = S_READY;
    end

    // Sweep starts at 1 because register 0 is never stored.
    always_ff @(posedge clk) begin
        if (!rst_n)               init_cnt <= AW'(1);
        else if (state == S_INIT) init_cnt <= init_cnt + AW'(1);
    end

    // Array has no reset; later write ports overwrite earlier ones on an address clash.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) begin
                regs[init_cnt] <= '0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
                        regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        for (int j = 0; j < NW; j++) begin
            if (bus.wr_en[j]) busy_clr[bus.wr_addr[j*AW +: AW]] = 1'b1;
        end
        if (bus.iss_en) busy_set[bus.iss_addr] = 1'b1;
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     busy <= '0;
        else if (ready) busy <= busy_next;
    end

    // Reads return zero until the sweep finishes; bypass picks the highest matching write port.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            if (ready) begin
                bus.rd_busy[i] = busy[bus.rd_addr[i*AW +: AW]];
                if (bus.rd_addr[i*AW +: AW] != '0) begin
                    bus.rd_data[i*XLEN +: XLEN] = regs[bus.rd_addr[i*AW +: AW]];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NW; j++) begin
                            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])
                                bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    assign bus.dbg_data = (ready && bus.dbg_addr != '0) ? regs[bus.dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NR=2, NW=2, BYPASS=1): vector table driven through
// a scoreboard queue, plus hand sequences for the init sweep and mid-run reset.
module tb_regfile_mp;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;

    typedef struct {
        logic [1:0]  wr_en;
        logic [4:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  ra0, ra1, dbg_a;
        logic [63:0] exp_rd0, exp_rd1;
        logic [1:0]  exp_busy;
        logic [63:0] exp_dbg;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   vec_idx;
    vec_t exp_q[$];
    vec_t tbl[$];

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW)) bus();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW), .BYPASS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(logic [1:0] we, logic [4:0] wa0, logic [63:0] wd0,
                                 logic [4:0] wa1, logic [63:0] wd1, logic ie, logic [4:0] ia,
                                 logic [4:0] ra0, logic [4:0] ra1, logic [4:0] da,
                                 logic [63:0] e0, logic [63:0] e1, logic [1:0] eb,
                                 logic [63:0] ed);
        vec_t v;
        v.wr_en = we;  v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iss_en = ie; v.iss_addr = ia;
        v.ra0 = ra0;   v.ra1 = ra1; v.dbg_a = da;
        v.exp_rd0 = e0; v.exp_rd1 = e1; v.exp_busy = eb; v.exp_dbg = ed;
        return v;
    endfunction

    function automatic logic [63:0] fill_val(int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vec %0d): got %h expected %h", name, vec_idx, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.rd_addr  = '0;
        bus.dbg_addr = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.wr_en    = v.wr_en;
        bus.wr_addr  = {v.wa1, v.wa0};
        bus.wr_data  = {v.wd1, v.wd0};
        bus.iss_en   = v.iss_en;
        bus.iss_addr = v.iss_addr;
        bus.rd_addr  = {v.ra1, v.ra0};
        bus.dbg_addr = v.dbg_a;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            cmp("rd_data0", bus.rd_data[63:0],   e.exp_rd0);
            cmp("rd_data1", bus.rd_data[127:64], e.exp_rd1);
            cmp("rd_busy",  64'(bus.rd_busy),    64'(e.exp_busy));
            cmp("dbg_data", bus.dbg_data,        e.exp_dbg);
            cmp("init_done", 64'(bus.init_done), 64'd1);
        end
    endtask

    // Caller is at a negedge; outputs are sampled 1ns later, the next posedge commits.
    task automatic runVec(input vec_t v);
        applyStimulus(v);
        #1;
        checkOutput();
        vec_idx++;
        @(negedge clk);
    endtask

    task automatic waitInit(input bit pulse_writes);
        int cycles;
        cycles = 0;
        driveIdle();
        if (pulse_writes) begin
            bus.wr_en    = 2'b01;
            bus.wr_addr  = {5'd0, 5'd5};
            bus.wr_data  = {64'd0, 64'hDEAD};
            bus.iss_en   = 1'b1;
            bus.iss_addr = 5'd5;
        end
        bus.rd_addr  = {5'd5, 5'd20};
        bus.dbg_addr = 5'd20;
        while (!bus.init_done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == 3) begin
                cmp("init_rd_data0", bus.rd_data[63:0], 64'd0);
                cmp("init_dbg_data", bus.dbg_data, 64'd0);
                cmp("init_rd_busy", 64'(bus.rd_busy), 64'd0);
                cmp("init_done_low", 64'(bus.init_done), 64'd0);
            end
            if (cycles == 10) driveIdle();
        end
        driveIdle();
        cmp("init_cycles", 64'(cycles), 64'd31);
    endtask

    initial begin
        logic b;
        errors  = 0;
        checks  = 0;
        vec_idx = 0;
        rst_n   = 1'b0;
        driveIdle();

        // Hand-derived READY-state table; each row is one clock cycle.
        tbl.push_back(mkv(2'b01, 5'd7, 64'h1234_5678_9ABC_DEF0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd7, 5'd3, 5'd7, 64'h1234_5678_9ABC_DEF0, 64'd0, 2'b00, 64'd0));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd7, 5'd7, 5'd7, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                          2'b00, 64'h1234_5678_9ABC_DEF0));
        tbl.push_back(mkv(2'b01, 5'd0, '1, 5'd0, 64'd0, 1'b1, 5'd0,
                          5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 64'd0));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 64'd0));
        tbl.push_back(mkv(2'b11, 5'd3, 64'hAA, 5'd3, 64'hBB, 1'b0, 5'd0,
                          5'd3, 5'd3, 5'd3, 64'hBB, 64'hBB, 2'b00, 64'd0));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd3, 5'd7, 5'd3, 64'hBB, 64'h1234_5678_9ABC_DEF0, 2'b00, 64'hBB));
        tbl.push_back(mkv(2'b11, 5'd4, 64'h44, 5'd6, 64'h66, 1'b0, 5'd0,
                          5'd4, 5'd6, 5'd4, 64'h44, 64'h66, 2'b00, 64'd0));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd4, 5'd6, 5'd6, 64'h44, 64'h66, 2'b00, 64'h66));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9,
                          5'd9, 5'd9, 5'd9, 64'd0, 64'd0, 2'b00, 64'd0));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd9, 5'd1, 5'd9, 64'd0, 64'd0, 2'b01, 64'd0));
        tbl.push_back(mkv(2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd9, 5'd9, 5'd9, 64'h99, 64'h99, 2'b11, 64'd0));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd9, 5'd9, 5'd9, 64'h99, 64'h99, 2'b00, 64'h99));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9,
                          5'd9, 5'd9, 5'd9, 64'h99, 64'h99, 2'b00, 64'h99));
        tbl.push_back(mkv(2'b10, 5'd0, 64'd0, 5'd9, 64'h9A, 1'b1, 5'd9,
                          5'd9, 5'd9, 5'd9, 64'h9A, 64'h9A, 2'b11, 64'h99));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd9, 5'd9, 5'd9, 64'h9A, 64'h9A, 2'b11, 64'h9A));
        tbl.push_back(mkv(2'b01, 5'd9, 64'h9B, 5'd0, 64'd0, 1'b1, 5'd10,
                          5'd9, 5'd9, 5'd9, 64'h9B, 64'h9B, 2'b11, 64'h9A));
        tbl.push_back(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                          5'd9, 5'd10, 5'd10, 64'h9B, 64'd0, 2'b10, 64'd0));

        repeat (2) @(negedge clk);
        cmp("reset_init_done", 64'(bus.init_done), 64'd0);
        cmp("reset_rd_busy", 64'(bus.rd_busy), 64'd0);

        rst_n = 1'b1;
        waitInit(1'b1);
        for (int k = 0; k < NREG; k++)
            runVec(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                       5'(k), 5'(31 - k), 5'(k), 64'd0, 64'd0, 2'b00, 64'd0));

        foreach (tbl[n]) runVec(tbl[n]);

        for (int k = 1; k < NREG; k++) begin
            b = (k == 2 || k == 5 || k == 17);
            runVec(mkv(2'b01, 5'(k), fill_val(k), 5'd0, 64'd0, b, 5'(k),
                       5'(k), 5'd0, 5'd0, fill_val(k), 64'd0, {1'b0, k == 10}, 64'd0));
        end
        for (int k = 1; k < NREG; k++) begin
            b = (k == 2 || k == 5 || k == 17);
            runVec(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                       5'(k), 5'(k), 5'(k), fill_val(k), fill_val(k), {b, b}, fill_val(k)));
        end

        driveIdle();
        rst_n = 1'b0;
        @(negedge clk);
        cmp("midrun_init_done", 64'(bus.init_done), 64'd0);
        rst_n = 1'b1;
        waitInit(1'b0);
        for (int k = 0; k < NREG; k++)
            runVec(mkv(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0,
                       5'(k), 5'(k), 5'(k), 64'd0, 64'd0, 2'b00, 64'd0));

        if (exp_q.size() != 0) cmp("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the NPC core pipeline.
- Supports configurable width and depth, NR read ports and NW write ports.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for hazard detection.
- Post-reset init sweep that zeroes every register before the core may use the file.

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREG).
- NR, 2, number of read ports.
- NW, 1, number of write ports.
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = write visible next cycle only.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- init_done  out  1  high once the init sweep is complete.
- rd_addr  in  NR*AW  packed read addresses; port i = [i*AW +: AW].
- rd_data  out  NR*XLEN  packed read data; combinational.
- rd_busy  out  NR  busy bit of each addressed register; combinational.
- wr_en  in  NW  write enables.
- wr_addr  in  NW*AW  packed write addresses.
- wr_data  in  NW*XLEN  packed write data.
- iss_en  in  1  mark iss_addr busy (an instruction with that destination issued).
- iss_addr  in  AW  destination being issued.
- dbg_addr  in  AW  debug/difftest read address.
- dbg_data  out  XLEN  debug read data; combinational, never bypassed.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to INIT, sweep counter = 1, all busy bits = 0, init_done = 0.
  - Array contents are not touched on the reset cycle itself.
- INIT state:
  - Each cycle writes 0 to regs[counter], then increments the counter.
  - The cycle that writes NREG-1 moves to READY; init_done rises on the next cycle.
  - Total NREG-1 cycles after rst_n deasserts.
  - wr_en and iss_en are ignored during INIT.
  - rd_data and dbg_data return 0; rd_busy = 0.
- READY state: held until rst_n is asserted again.
  - Reset mid-operation restarts INIT and clears all busy bits.
- Register 0:
  - Hard-wired zero; reads always return 0 on every port, including bypass.
  - Writes to 0 are dropped.
  - Busy bit of 0 is never set.
- Write, READY only:
  - At posedge, for each port j with wr_en[j] and wr_addr[j]!=0: regs[wr_addr[j]] <= wr_data[j].
  - Same-address conflict between ports: the highest-index port wins.
- Read:
  - rd_data[i] = regs[rd_addr[i]], combinational.
  - If BYPASS=1 and some enabled write port targets rd_addr[i] (non-zero) this cycle, return that write data instead (highest-index matching port).
  - If BYPASS=0, the written value is visible from the next cycle.
- Scoreboard, READY only, per register r:
  - clear = any enabled write port addresses r.
  - set = iss_en && iss_addr==r && r!=0.
  - Next busy = set ? 1 : (clear ? 0 : busy). Set wins over a same-cycle clear (new producer supersedes).
  - rd_busy[i] = busy[rd_addr[i]]; it reflects registered state and is not bypassed.
- Debug port: dbg_data = regs[dbg_addr] (0 for address 0); no bypass.
- Width rules:
  - Addresses are exactly AW bits, so no out-of-range index exists.
  - Data is passed through unmodified; no sign handling.

Test Plan:
- Init sweep: NREG=32, release rst_n → init_done low for 31 cycles then high; read all 32 regs → all 0; wr_en pulsed during INIT to reg 5 with 0xDEAD → reg 5 still 0 after init.
- Write/read with BYPASS=1, NW=1: write reg 7 = 0x1234_5678_9ABC_DEF0 → rd_data port 0 addr 7 shows the value in the same cycle; port 1 shows it the next cycle; dbg_data shows it only the next cycle.
- x0 rule: write reg 0 = 0xFFFF... with iss_en to reg 0 → all read ports and dbg read 0; rd_busy for addr 0 stays 0.
- Dual-write conflict, NW=2: both ports write reg 3 (0xAA, 0xBB) in the same cycle → reg 3 = 0xBB; bypass read also returns 0xBB.
- Scoreboard: iss reg 9 → rd_busy high next cycle; write reg 9 → busy low next cycle; iss reg 9 and write reg 9 in the same cycle while busy → busy stays 1.
- Mid-run reset: fill regs 1..31 with nonzero values and set several busy bits, assert rst_n for 1 cycle → init_done=0, busy all 0; after 31 cycles all regs read 0.
